// File: rtl/glitch_free_div_sel.sv
// glitch_free_div_sel: registered 50%-duty divided clock with glitch-free run-time switching among N_CH divide channels
module glitch_free_div_sel #(
    parameter int N_CH    = 4,
    parameter int SEL_W   = 3,
    parameter int DIV_W   = 8,
    parameter int GAP     = 2,
    parameter int RST_SEL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DIV_W-1:0]  div_cfg,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   sel_vld,
    output logic                   sel_rdy,
    output logic                   sel_err,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   switching,
    output logic                   clk_out
);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {S_RUN, S_WAIT_LOW, S_GAP} state_t;
    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d, cur_div_q, cur_div_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
    logic [SEL_W-1:0]   tgt_q, tgt_d, cur_sel_q, cur_sel_d;
    logic               clk_out_q, clk_out_d, sel_err_q, sel_err_d;
    logic [DIV_W-1:0]   d_arr [2**SEL_W];
    logic               phase_end, gap_end;
    // out-of-range selects read as an off channel so indexing is always legal
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_d
        if (k < N_CH) begin : g_on
            assign d_arr[k] = div_cfg[k*DIV_W +: DIV_W];
        end else begin : g_off
            assign d_arr[k] = '0;
        end
    end
    assign phase_end = cur_div_q != '0 && cnt_q == cur_div_q - DIV_W'(1);
    assign gap_end   = gap_cnt_q == GW'(GAP - 1);
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
        cur_div_d = cur_div_q;
        tgt_d     = tgt_q;
        cur_sel_d = cur_sel_q;
        clk_out_d = clk_out_q;
        sel_err_d = 1'b0;
        if (state_q == S_GAP) begin
            clk_out_d = 1'b0;
            gap_cnt_d = gap_cnt_q + GW'(1);
            if (gap_end) begin
                state_d   = S_RUN;
                cur_sel_d = tgt_q;
                cur_div_d = d_arr[tgt_q];
                cnt_d     = '0;
                clk_out_d = d_arr[tgt_q] != '0;
            end
        end else if (cur_div_q == '0) begin
            clk_out_d = 1'b0;
            if (state_q == S_WAIT_LOW) begin
                state_d   = S_GAP;
                gap_cnt_d = '0;
                cnt_d     = '0;
            end
        end else if (phase_end) begin
            cnt_d     = '0;
            cur_div_d = d_arr[cur_sel_q];
            // a pending switch swallows the rising edge and stretches the low phase by GAP
            if (state_q == S_WAIT_LOW && !clk_out_q) begin
                state_d   = S_GAP;
                gap_cnt_d = '0;
            end else begin
                clk_out_d = !clk_out_q;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        if (state_q == S_RUN && sel_vld) begin
            if (32'(sel) >= N_CH) begin
                sel_err_d = 1'b1;
            end else if (sel != cur_sel_q) begin
                tgt_d   = sel;
                state_d = S_WAIT_LOW;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_GAP;
            cnt_q     <= '0;
            gap_cnt_q <= '0;
            cur_div_q <= '0;
            tgt_q     <= SEL_W'(RST_SEL);
            cur_sel_q <= SEL_W'(RST_SEL);
            clk_out_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_cnt_q <= gap_cnt_d;
            cur_div_q <= cur_div_d;
            tgt_q     <= tgt_d;
            cur_sel_q <= cur_sel_d;
            clk_out_q <= clk_out_d;
            sel_err_q <= sel_err_d;
        end
    end
    assign sel_rdy   = state_q == S_RUN;
    assign switching = state_q != S_RUN;
    assign cur_sel   = cur_sel_q;
    assign sel_err   = sel_err_q;
    assign clk_out   = clk_out_q;
endmodule

// File: tb/tb_glitch_free_div_sel.sv
// tb_glitch_free_div_sel: directed table, corner sequences and random traffic against a phase-plan model
module tb_glitch_free_div_sel;
    localparam int N_CH = 4;
    localparam int GAP  = 2;
    typedef struct {
        bit         vld;
        logic [2:0] sel;
        bit         clk_o;
        logic [2:0] cs;
        bit         sw;
        bit         err;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg;
    logic [2:0]  sel;
    logic        vld;
    logic        sel_rdy, sel_err, switching, clk_out;
    logic [2:0]  cur_sel;
    int          n_tests = 0;
    int          n_fail = 0;
    vec_t        tbl[$];
    bit          plan[$];
    int          m_sel, m_tgt;
    bit          m_busy, m_gap, m_lvl, m_off, m_err, m_out;
    glitch_free_div_sel #(.N_CH(4), .SEL_W(3), .DIV_W(8), .GAP(2), .RST_SEL(0)) dut (
        .clk(clk), .rst_n(rst_n), .div_cfg(cfg), .sel(sel), .sel_vld(vld),
        .sel_rdy(sel_rdy), .sel_err(sel_err), .cur_sel(cur_sel),
        .switching(switching), .clk_out(clk_out)
    );
    always #5 clk = ~clk;
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int dval(int ch);
        return ch < N_CH ? int'(cfg[ch*8 +: 8]) : 0;
    endfunction
    // The model plans whole phases: when the planned waveform runs out it appends the next phase
    // (D cycles of the opposite level, or GAP low cycles if a switch is pending at a low phase end).
    function automatic void model_reset();
        plan = {};
        for (int i = 0; i < GAP - 1; i++) plan.push_back(1'b0);
        m_sel = 0; m_tgt = 0; m_busy = 1; m_gap = 1; m_lvl = 0; m_off = 0; m_err = 0; m_out = 0;
    endfunction
    function automatic void model_edge();
        bit rdy = !m_busy;
        if (plan.size() == 0) begin
            if (m_gap) begin
                m_gap = 0; m_busy = 0; m_sel = m_tgt;
                m_off = dval(m_sel) == 0;
                m_lvl = !m_off;
                repeat (dval(m_sel)) plan.push_back(1'b1);
            end else if (m_busy && !m_lvl) begin
                m_gap = 1;
                repeat (GAP) plan.push_back(1'b0);
            end else if (!m_off) begin
                m_lvl = !m_lvl;
                repeat (dval(m_sel)) plan.push_back(m_lvl);
            end
        end
        m_out = plan.size() != 0 ? plan.pop_front() : 1'b0;
        m_err = rdy && vld && sel >= N_CH;
        if (rdy && vld && sel < N_CH && int'(sel) != m_sel) begin
            m_busy = 1;
            m_tgt  = int'(sel);
        end
    endfunction
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk("m_clk_out", clk_out, m_out);
        chk("m_cur_sel", cur_sel, m_sel);
        chk("m_sel_rdy", sel_rdy, !m_busy);
        chk("m_switching", switching, m_busy);
        chk("m_sel_err", sel_err, m_err);
    endtask
    task automatic add(int n, bit v, logic [2:0] s, bit c, logic [2:0] cs, bit sw, bit e);
        repeat (n) tbl.push_back('{v, s, c, cs, sw, e});
    endtask
    task automatic run_rows(int n);
        for (int i = 0; i < n; i++) begin
            vld = tbl[i].vld;
            sel = tbl[i].sel;
            step();
            chk($sformatf("row%0d_clk", i), clk_out, tbl[i].clk_o);
            chk($sformatf("row%0d_cur_sel", i), cur_sel, tbl[i].cs);
            chk($sformatf("row%0d_switching", i), switching, tbl[i].sw);
            chk($sformatf("row%0d_sel_rdy", i), sel_rdy, !tbl[i].sw);
            chk($sformatf("row%0d_sel_err", i), sel_err, tbl[i].err);
        end
        vld = 0;
    endtask
    task automatic do_reset(string tag);
        rst_n = 0;
        #1;
        chk({tag, "_clk"}, clk_out, 0);
        chk({tag, "_cur_sel"}, cur_sel, 0);
        chk({tag, "_switching"}, switching, 1);
        chk({tag, "_sel_rdy"}, sel_rdy, 0);
        chk({tag, "_sel_err"}, sel_err, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask
    task automatic len(bit lvl, output int n);
        n = 0;
        while (clk_out === lvl && n < 200) begin
            n++;
            step();
        end
    endtask
    task automatic wait_idle(string name);
        int n = 0;
        while (switching !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk(name, switching, 0);
    endtask
    initial begin
        int n;
        cfg = {8'd0, 8'd5, 8'd3, 8'd1};
        vld = 0;
        sel = 0;
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0);
        add(1, 1, 2, 0, 0, 1, 0);
        add(2, 0, 0, 0, 0, 1, 0);
        add(5, 0, 0, 1, 2, 0, 0);
        add(5, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 2, 0, 0);
        add(1, 1, 5, 1, 2, 0, 1);
        add(3, 0, 0, 1, 2, 0, 0);
        add(1, 0, 0, 0, 2, 0, 0);
        add(1, 1, 2, 0, 2, 0, 0);
        add(3, 0, 0, 0, 2, 0, 0);
        add(1, 0, 0, 1, 2, 0, 0);
        rst_n = 1;
        #2;
        do_reset("rst0");
        run_rows(tbl.size());
        step();
        cfg[2*8 +: 8] = 8'd4;
        len(1, n); chk("d_edit_cur_high", n, 4);
        len(0, n); chk("d_edit_low", n, 4);
        len(1, n); chk("d_edit_high", n, 4);
        vld = 1; sel = 3;
        step();
        vld = 0;
        chk("off_req_switching", switching, 1);
        wait_idle("off_switch_done");
        chk("off_cur_sel", cur_sel, 3);
        chk("off_clk", clk_out, 0);
        repeat (6) step();
        chk("off_hold_clk", clk_out, 0);
        vld = 1; sel = 1;
        step();
        vld = 0;
        chk("from_off_switching", switching, 1);
        len(0, n); chk("from_off_low", n, GAP + 1);
        chk("from_off_cur_sel", cur_sel, 1);
        len(1, n); chk("ch1_high", n, 3);
        len(0, n); chk("ch1_low", n, 3);
        vld = 1; sel = 0;
        step();
        sel = 2;
        wait_idle("hold_switch_done");
        chk("hold_not_taken", cur_sel, 0);
        step();
        chk("hold_taken_switching", switching, 1);
        vld = 0;
        n = 0;
        while (!m_gap && n < 50) begin
            step();
            n++;
        end
        chk("reach_gap", m_gap, 1);
        do_reset("rst_mid_gap");
        run_rows(6);
        for (int c = 0; c < 4000; c++) begin
            vld = $urandom_range(0, 5) == 0;
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) begin
                int k = $urandom_range(0, 2);
                cfg[k*8 +: 8] = 8'($urandom_range(1, 6));
            end
            step();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
